cache_mem_arbiter: RTL and testbench

- Sequences 256-bit cache-line transfers between two cache requesters and one 32-bit word-wide memory port.
- Requester 0 is the instruction cache; requester 1 is the data cache.
- Each line transfer is a fill (read) or write-back (write) of 8 words, issued one beat at a time.
- Read data is assembled into a 256-bit line buffer that feeds the cache line adapter.

---
 rtl/cache_mem_arbiter.sv | 152 +++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
// Two-requester cache-line sequencer: moves WORDS-beat lines between an icache/dcache pair and one 32-bit memory port.
// Optional ARB_RR_EN selects round-robin tie-breaking; default build uses fixed dcache priority.
// Valid/ready contract: mem_req is a request held stable until mem_ack is sampled high on a rising edge;
// each such edge completes exactly one beat. done is a single-cycle pulse with no back-pressure.
// Debug: dbg_state encodes IDLE=0, XFER=1, DONE=2; dbg_beat is the current beat index.
module cache_mem_arbiter #(
  parameter int WORDS  = 8,
  parameter int ADDR_W = 32
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic [1:0]                 req,
  input  logic [1:0]                 we,
  input  logic [ADDR_W-1:0]          addr0,
  input  logic [ADDR_W-1:0]          addr1,
  input  logic [32*WORDS-1:0]        wdata0,
  input  logic [32*WORDS-1:0]        wdata1,
  output logic [1:0]                 done,
  output logic                       busy,
  output logic [32*WORDS-1:0]        rdata,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [31:0]                mem_wdata,
  input  logic [31:0]                mem_rdata,
  input  logic                       mem_ack,
  output logic [1:0]                 dbg_state,
  output logic [$clog2(WORDS)-1:0]   dbg_beat
);

  localparam int LINE_W = 32 * WORDS;
  localparam int BEAT_W = $clog2(WORDS);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(4 * WORDS - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_XFER = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              grant_q, grant_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] line_addr_q, line_addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic [LINE_W-1:0] buf_q, buf_d;
  logic              win;

`ifdef ARB_RR_EN
  logic last_grant_q, last_grant_d;

  // On a tie the requester that did not win last time goes first.
  always_comb begin
    case (req)
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      default: win = ~last_grant_q;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) last_grant_q <= 1'b1;
    else        last_grant_q <= last_grant_d;
  end
`else
  // Fixed priority: the dcache wins every tie.
  always_comb begin
    case (req)
      2'b01:   win = 1'b0;
      default: win = 1'b1;
    endcase
  end
`endif

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    grant_d     = grant_q;
    we_d        = we_q;
    line_addr_d = line_addr_q;
    wdata_d     = wdata_q;
    buf_d       = buf_q;
`ifdef ARB_RR_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req != 2'b00) begin
          state_d     = S_XFER;
          beat_d      = '0;
          grant_d     = win;
          we_d        = win ? we[1] : we[0];
          line_addr_d = (win ? addr1 : addr0) & ~OFF_MASK;
          wdata_d     = win ? wdata1 : wdata0;
`ifdef ARB_RR_EN
          last_grant_d = win;
`endif
        end
      end
      S_XFER: begin
        if (mem_ack) begin
          if (!we_q) buf_d[32*beat_q +: 32] = mem_rdata;
          if (beat_q == LAST_BEAT) state_d = S_DONE;
          else                     beat_d  = beat_q + BEAT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= S_IDLE;
      beat_q      <= '0;
      grant_q     <= 1'b0;
      we_q        <= 1'b0;
      line_addr_q <= '0;
      wdata_q     <= '0;
      buf_q       <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      grant_q     <= grant_d;
      we_q        <= we_d;
      line_addr_q <= line_addr_d;
      wdata_q     <= wdata_d;
      buf_q       <= buf_d;
    end
  end

  // Line offset bits of line_addr_q are zero, so OR-ing the beat offset never carries out of the line.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state_q == S_XFER) begin
      mem_req   = 1'b1;
      mem_we    = we_q;
      mem_addr  = line_addr_q | ADDR_W'({beat_q, 2'b00});
      mem_wdata = wdata_q[32*beat_q +: 32];
    end
  end

  assign done      = (state_q == S_DONE) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
  assign busy      = (state_q != S_IDLE);
  assign rdata     = buf_q;
  assign dbg_state = state_q;
  assign dbg_beat  = beat_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: randomized line transfers against a queue-based reference model.
// Build with +define+ARB_RR_EN to check the round-robin variant.
module tb_cache_mem_arbiter;

  logic         clk;
  logic         RST_N;
  logic [1:0]   req, we;
  logic [31:0]  addr0, addr1;
  logic [255:0] wdata0, wdata1;
  logic [1:0]   done;
  logic         busy;
  logic [255:0] rdata;
  logic         mem_req, mem_we, mem_ack;
  logic [31:0]  mem_addr, mem_wdata, mem_rdata;
  logic [1:0]   dbg_state;
  logic [2:0]   dbg_beat;

  cache_mem_arbiter #(.WORDS(8), .ADDR_W(32)) dut (
    .CLK(clk), .RST_N(RST_N), .req(req), .we(we), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .done(done), .busy(busy), .rdata(rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .dbg_state(dbg_state), .dbg_beat(dbg_beat)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ---------------- memory stub ----------------
  int          mem_mode = 0;
  logic [31:0] salt = 32'h0;
  int          stall_beat = 0;
  int          stall_len = 0;
  int          stall_cnt = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_mode == 0) return 32'h100 + {29'd0, a[4:2]};
    return (a * 32'h9E3779B1) ^ salt;
  endfunction

  always @(negedge clk) begin
    if (!mem_req) begin
      stall_cnt = 0;
      mem_ack   = 1'b0;
    end else if (int'(mem_addr[4:2]) == stall_beat && stall_cnt < stall_len) begin
      stall_cnt = stall_cnt + 1;
      mem_ack   = 1'b0;
    end else begin
      mem_ack   = 1'b1;
    end
    mem_rdata = mem_word(mem_addr);
  end

  // ---------------- reference model + scoreboard ----------------
  logic         model_last = 1'b1;
  logic [255:0] model_buf  = '0;
  logic [64:0]  exp_q[$];        // {addr, we, wdata} per beat, in order
  logic [1:0]   exp_done_q[$];
  logic [255:0] exp_rdata_q[$];
  int           exp_cyc_q[$];

  function automatic logic model_pick(input logic [1:0] r);
    if (r == 2'b01) return 1'b0;
    if (r == 2'b10) return 1'b1;
`ifdef ARB_RR_EN
    return ~model_last;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[32*k +: 32] = $urandom;
    return l;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    exp_done_q.delete();
    exp_rdata_q.delete();
    exp_cyc_q.delete();
    model_last = 1'b1;
    model_buf  = '0;
  endtask

  // Called at a falling edge while the DUT is idle; the next rising edge is the grant edge.
  task automatic issue(input logic [1:0] r, input logic [1:0] w, input logic [31:0] a0,
                       input logic [31:0] a1, input logic [255:0] d0, input logic [255:0] d1,
                       input int sb, input int sl);
    logic         who, wb;
    logic [31:0]  line;
    logic [255:0] data;
    who  = model_pick(r);
    model_last = who;
    line = (who ? a1 : a0) & ~32'h1F;
    data = who ? d1 : d0;
    wb   = who ? w[1] : w[0];
    for (int k = 0; k < 8; k++) begin
      exp_q.push_back({line + 32'(4 * k), wb, data[32*k +: 32]});
      if (!wb) model_buf[32*k +: 32] = mem_word(line + 32'(4 * k));
    end
    exp_done_q.push_back(who ? 2'b10 : 2'b01);
    exp_rdata_q.push_back(model_buf);
    exp_cyc_q.push_back(cyc + 1 + 8 + sl);
    stall_beat = sb;
    stall_len  = sl;
    req = r; we = w; addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
  endtask

  // drop: 0 hold inputs, 1 deassert req after grant, 2 scramble all inputs after grant
  task automatic do_txn(input logic [1:0] r, input logic [1:0] w, input logic [31:0] a0,
                        input logic [31:0] a1, input logic [255:0] d0, input logic [255:0] d1,
                        input int sb, input int sl, input int drop);
    bit seen;
    issue(r, w, a0, a1, d0, d1, sb, sl);
    @(posedge clk);
    @(negedge clk);
    check("busy_after_grant", 256'(busy), 256'(1'b1));
    if (drop == 1) req = 2'b00;
    if (drop == 2) begin
      req = 2'($urandom); we = 2'($urandom); addr0 = $urandom; addr1 = $urandom;
      wdata0 = rand_line(); wdata1 = rand_line();
    end
    seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(negedge clk);
      if (done != 2'b00) seen = 1'b1;
    end
    check("done_seen", 256'(seen), 256'(1'b1));
    @(negedge clk);
    check("busy_idle", 256'(busy), 256'(1'b0));
    check("state_idle", 256'(dbg_state), 256'(2'd0));
    req = 2'b00;
  endtask

  // Monitor: compares every presented beat and completion against the expected queues.
  always begin
    @(negedge clk);
    #1;
    if (RST_N) begin
      if (mem_req) begin
        if (exp_q.size() == 0) check("beat_unexpected", 256'(mem_req), 256'(1'b0));
        else begin
          check("beat", 256'({mem_addr, mem_we, mem_wdata}), 256'(exp_q[0]));
          if (mem_ack) void'(exp_q.pop_front());
        end
      end
      if (done != 2'b00) begin
        if (exp_done_q.size() == 0) check("done_unexpected", 256'(done), 256'(2'b00));
        else begin
          check("done_vec", 256'(done), 256'(exp_done_q.pop_front()));
          check("done_cycle", 256'(cyc), 256'(exp_cyc_q.pop_front()));
          check("rdata", rdata, exp_rdata_q.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [255:0] l0, l1;
  bit           hit;

  initial begin
    RST_N = 1'b0; req = 2'b00; we = 2'b00; addr0 = '0; addr1 = '0;
    wdata0 = '0; wdata1 = '0; mem_ack = 1'b0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 256'(busy), 256'(1'b0));
    check("rst_done", 256'(done), 256'(2'b00));
    check("rst_rdata", rdata, 256'(0));
    check("rst_mem", 256'({mem_req, mem_we, mem_addr, mem_wdata}), 256'(0));
    check("rst_beat", 256'(dbg_beat), 256'(0));
    RST_N = 1'b1;
    repeat (2) @(negedge clk);

    // single fill with a known memory pattern
    mem_mode = 0;
    do_txn(2'b01, 2'b00, 32'h0000_1234, 32'h0, rand_line(), rand_line(), 0, 0, 0);

    // write-back from the dcache
    for (int k = 0; k < 8; k++) l1[32*k +: 32] = 32'hA0 + 32'(k);
    do_txn(2'b10, 2'b10, $urandom, 32'h0000_8000, rand_line(), l1, 0, 0, 0);

    // tie held across three transfers, the middle one stalled on beat 4
    mem_mode = 1; salt = $urandom;
    do_txn(2'b11, 2'b00, 32'h0000_2000, 32'h0000_3000, rand_line(), rand_line(), 0, 0, 0);
    do_txn(2'b11, 2'b00, 32'h0000_2020, 32'h0000_3020, rand_line(), rand_line(), 4, 3, 0);
    do_txn(2'b11, 2'b01, 32'h0000_2040, 32'h0000_3040, rand_line(), rand_line(), 0, 0, 0);

    // request withdrawn right after grant
    do_txn(2'b01, 2'b00, 32'h0000_4444, $urandom, rand_line(), rand_line(), 0, 0, 1);
    repeat (3) begin
      @(negedge clk);
      check("no_grant_idle", 256'(busy), 256'(1'b0));
    end

    // reset mid-transfer at beat 5
    issue(2'b01, 2'b00, 32'h0000_5000, 32'h0, rand_line(), rand_line(), 0, 0);
    @(posedge clk);
    hit = 1'b0;
    for (int i = 0; i < 32 && !hit; i++) begin
      @(negedge clk);
      if (dbg_state == 2'd1 && dbg_beat == 3'd5) hit = 1'b1;
    end
    check("reach_beat5", 256'(hit), 256'(1'b1));
    #2 RST_N = 1'b0;
    #1;
    check("amid_rst_mem_req", 256'(mem_req), 256'(1'b0));
    check("amid_rst_busy", 256'(busy), 256'(1'b0));
    check("amid_rst_beat", 256'(dbg_beat), 256'(0));
    check("amid_rst_rdata", rdata, 256'(0));
    model_reset();
    req = 2'b00;
    repeat (2) @(negedge clk);
    RST_N = 1'b1;
    repeat (2) @(negedge clk);
    do_txn(2'b01, 2'b00, 32'h0000_6000, 32'h0, rand_line(), rand_line(), 0, 0, 0);

    // randomized traffic
    for (int t = 0; t < 40; t++) begin
      salt = $urandom;
      l0 = rand_line(); l1 = rand_line();
      do_txn(2'($urandom_range(1, 3)), 2'($urandom), $urandom, $urandom, l0, l1,
             $urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    check("beats_drained", 256'(exp_q.size()), 256'(0));
    check("dones_drained", 256'(exp_done_q.size()), 256'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
